ds18b20_sampler: RTL

Autonomous DS18B20 sampling sequencer; the parametrised successor to the single-shot presence checker. Drives the existing ds18b20 one-wire controller's command interface through the full sequence: reset/detect, skip ROM, convert T, conversion wait, reset/detect, skip ROM, read scratchpad, N byte reads. Sits between the controller and user logic, and publishes a signed temperature, status and alarm flags, periodically or on demand.

---
 rtl/ds18b20_sampler.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ds18b20_sampler.sv
// Autonomous DS18B20 sampling sequencer driving the one-wire controller command interface.
// Optional build macro DS18B20_SAMPLER_CRC_EN: read all 9 scratchpad bytes and verify Dallas CRC-8.
module ds18b20_sampler #(
    parameter int SAMPLE_CYC = 48000000,
    parameter int CONV_CYC   = 36000000,
    parameter int TO_CYC     = 96000,
    parameter int RD_BYTES   = 2,
    parameter int ALARM_HI   = 480
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic [5:0]  o_cmd,
    output logic        o_cmd_en,
    input  logic        i_busy,
    input  logic        i_detect,
    input  logic [7:0]  i_data,
    output logic [15:0] o_temp,
    output logic        o_temp_valid,
    output logic        o_present,
    output logic        o_err_nodev,
    output logic        o_err_timeout,
    output logic        o_err_crc,
    output logic        o_alarm,
    output logic        o_busy
);

`ifdef DS18B20_SAMPLER_CRC_EN
    localparam int NB = 9;
`else
    localparam int NB = RD_BYTES;
`endif

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_RST1   = 4'd1;
    localparam logic [3:0] S_SKIP1  = 4'd2;
    localparam logic [3:0] S_CONV   = 4'd3;
    localparam logic [3:0] S_CWAIT  = 4'd4;
    localparam logic [3:0] S_RST2   = 4'd5;
    localparam logic [3:0] S_SKIP2  = 4'd6;
    localparam logic [3:0] S_RDCMD  = 4'd7;
    localparam logic [3:0] S_RDBYTE = 4'd8;
`ifdef DS18B20_SAMPLER_CRC_EN
    localparam logic [3:0] S_CRCB   = 4'd9;
`endif
    localparam logic [3:0] S_DONE   = 4'd10;
    localparam logic [3:0] S_ERR    = 4'd11;

    localparam logic signed [15:0] ALARM_V = 16'(ALARM_HI);

    logic [3:0]  r_state;
    logic [1:0]  r_phase;
    logic [31:0] r_to;
    logic [31:0] r_wait;
    logic [31:0] r_period;
    logic [3:0]  r_k;
    logic [7:0]  r_b0;
    logic [7:0]  r_b1;
    logic [5:0]  r_cmd;
    logic        r_cmd_en;
    logic [15:0] r_temp;
    logic        r_valid;
    logic        r_present;
    logic        r_err_nodev;
    logic        r_err_timeout;
    logic        r_alarm;
`ifdef DS18B20_SAMPLER_CRC_EN
    logic [7:0]  r_crc;
    logic [7:0]  r_sh;
    logic [2:0]  r_bit;
    logic        r_err_crc;
`endif

    logic [3:0]  w_nxt;
    logic        w_enter;
    logic        w_is_cmd;
    logic        w_wrap;
    logic        w_cmd_done;
    logic        w_cmd_tmo;
    logic        w_crc_ok;

    function automatic logic [5:0] cmd_of(input logic [3:0] s);
        case (s)
            S_RST1, S_RST2:   cmd_of = 6'd1;
            S_SKIP1, S_SKIP2: cmd_of = 6'd2;
            S_CONV:           cmd_of = 6'd3;
            S_RDCMD:          cmd_of = 6'd4;
            S_RDBYTE:         cmd_of = 6'd5;
            default:          cmd_of = 6'd0;
        endcase
    endfunction

`ifdef DS18B20_SAMPLER_CRC_EN
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic [7:0] n;
        n = {1'b0, c[7:1]};
        if (c[0] ^ b) n = n ^ 8'h8C;
        crc_step = n;
    endfunction
    assign w_crc_ok = (r_crc == 8'd0);
`else
    assign w_crc_ok = 1'b1;
`endif

    assign w_is_cmd = (r_state == S_RST1) || (r_state == S_SKIP1) || (r_state == S_CONV) ||
                      (r_state == S_RST2) || (r_state == S_SKIP2) || (r_state == S_RDCMD) ||
                      (r_state == S_RDBYTE);
    assign w_wrap     = (SAMPLE_CYC != 0) && (r_period == 32'(SAMPLE_CYC - 1));
    // Busy is only trusted from the third cycle of a command; the first two cover issue and guard.
    assign w_cmd_done = w_is_cmd && (r_phase == 2'd2) && !i_busy;
    assign w_cmd_tmo  = w_is_cmd && (r_phase == 2'd2) && i_busy && (r_to >= 32'(TO_CYC - 1));

    always_comb begin
        w_nxt   = r_state;
        w_enter = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start || w_wrap) begin
                    w_nxt   = S_RST1;
                    w_enter = 1'b1;
                end
            end
            S_CWAIT: begin
                if (r_wait == 32'd0) begin
                    w_nxt   = S_RST2;
                    w_enter = 1'b1;
                end
            end
`ifdef DS18B20_SAMPLER_CRC_EN
            S_CRCB: begin
                if (r_bit == 3'd7) begin
                    w_nxt   = (r_k == 4'(NB)) ? S_DONE : S_RDBYTE;
                    w_enter = 1'b1;
                end
            end
`endif
            S_DONE, S_ERR: begin
                w_nxt   = S_IDLE;
                w_enter = 1'b1;
            end
            default: begin
                if (w_cmd_tmo) begin
                    w_nxt   = S_ERR;
                    w_enter = 1'b1;
                end else if (w_cmd_done) begin
                    w_enter = 1'b1;
                    case (r_state)
                        S_RST1:   w_nxt = i_detect ? S_SKIP1 : S_ERR;
                        S_SKIP1:  w_nxt = S_CONV;
                        S_CONV:   w_nxt = S_CWAIT;
                        S_RST2:   w_nxt = i_detect ? S_SKIP2 : S_ERR;
                        S_SKIP2:  w_nxt = S_RDCMD;
                        S_RDCMD:  w_nxt = S_RDBYTE;
`ifdef DS18B20_SAMPLER_CRC_EN
                        S_RDBYTE: w_nxt = S_CRCB;
`else
                        S_RDBYTE: w_nxt = (r_k == 4'(NB - 1)) ? S_DONE : S_RDBYTE;
`endif
                        default:  w_nxt = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_period <= 32'd0;
        end else if (w_wrap) begin
            r_period <= 32'd0;
        end else if (SAMPLE_CYC != 0) begin
            r_period <= r_period + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_phase       <= 2'd0;
            r_to          <= 32'd0;
            r_wait        <= 32'd0;
            r_k           <= 4'd0;
            r_b0          <= 8'd0;
            r_b1          <= 8'd0;
            r_cmd         <= 6'd0;
            r_cmd_en      <= 1'b0;
            r_temp        <= 16'd0;
            r_valid       <= 1'b0;
            r_present     <= 1'b0;
            r_err_nodev   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_alarm       <= 1'b0;
`ifdef DS18B20_SAMPLER_CRC_EN
            r_crc         <= 8'd0;
            r_sh          <= 8'd0;
            r_bit         <= 3'd0;
            r_err_crc     <= 1'b0;
`endif
        end else begin
            r_valid  <= 1'b0;
            r_cmd_en <= 1'b0;
            r_cmd    <= 6'd0;
            if (r_phase != 2'd2) r_phase <= r_phase + 2'd1;
            if (w_is_cmd) r_to <= r_to + 32'd1;
            if (r_state == S_CWAIT) r_wait <= r_wait - 32'd1;
`ifdef DS18B20_SAMPLER_CRC_EN
            if (r_state == S_CRCB) begin
                r_crc <= crc_step(r_crc, r_sh[0]);
                r_sh  <= {1'b0, r_sh[7:1]};
                r_bit <= r_bit + 3'd1;
            end
`endif
            if (w_cmd_done && ((r_state == S_RST1) || (r_state == S_RST2)))
                r_present <= i_detect;
            if (w_cmd_done && (r_state == S_RDCMD)) begin
                r_k <= 4'd0;
`ifdef DS18B20_SAMPLER_CRC_EN
                r_crc <= 8'd0;
`endif
            end
            if (w_cmd_done && (r_state == S_RDBYTE)) begin
                if (r_k == 4'd0) r_b0 <= i_data;
                if (r_k == 4'd1) r_b1 <= i_data;
                r_k <= r_k + 4'd1;
`ifdef DS18B20_SAMPLER_CRC_EN
                r_sh  <= i_data;
                r_bit <= 3'd0;
`endif
            end
            if (r_state == S_DONE) begin
                r_err_nodev   <= 1'b0;
                r_err_timeout <= 1'b0;
                if (w_crc_ok) begin
                    r_temp  <= {r_b1, r_b0};
                    r_valid <= 1'b1;
                    r_alarm <= ($signed({r_b1, r_b0}) >= ALARM_V);
                end
`ifdef DS18B20_SAMPLER_CRC_EN
                r_err_crc <= !w_crc_ok;
`endif
            end
            if (w_enter) begin
                r_state  <= w_nxt;
                r_phase  <= 2'd0;
                r_to     <= 32'd0;
                r_cmd    <= cmd_of(w_nxt);
                r_cmd_en <= (cmd_of(w_nxt) != 6'd0);
                if (w_nxt == S_CWAIT) r_wait <= 32'(CONV_CYC - 1);
                if (w_nxt == S_ERR) begin
                    r_err_nodev   <= !w_cmd_tmo;
                    r_err_timeout <= w_cmd_tmo;
`ifdef DS18B20_SAMPLER_CRC_EN
                    r_err_crc     <= 1'b0;
`endif
                end
            end
        end
    end

    assign o_cmd         = r_cmd;
    assign o_cmd_en      = r_cmd_en;
    assign o_temp        = r_temp;
    assign o_temp_valid  = r_valid;
    assign o_present     = r_present;
    assign o_err_nodev   = r_err_nodev;
    assign o_err_timeout = r_err_timeout;
`ifdef DS18B20_SAMPLER_CRC_EN
    assign o_err_crc     = r_err_crc;
`else
    assign o_err_crc     = 1'b0;
`endif
    assign o_alarm       = r_alarm;
    assign o_busy        = (r_state != S_IDLE);

endmodule
